// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - 4-entry writeback FIFO feeding the register file write ports
module regfile_writeback_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [3:0]  dstE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        hold,
  input  logic        flush,
  output logic [3:0]  writeRegE,
  output logic [3:0]  writeRegM,
  output logic [63:0] writeDataE,
  output logic [63:0] writeDataM,
  input  logic [3:0]  qRegA,
  input  logic [3:0]  qRegB,
  output logic        busyA,
  output logic        busyB
);

  localparam logic [3:0] NoReg = 4'hF;

  logic [3:0]  fifoDstE [4];
  logic [3:0]  fifoDstM [4];
  logic [63:0] fifoValE [4];
  logic [63:0] fifoValM [4];
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  count;
  logic        push;
  logic        pop;
  logic [3:0]  entryValid;

  assign inReady = reset && (count != 3'd4);
  assign push    = inValid && inReady && !flush;
  assign pop     = (count != 3'd0) && !hold && !flush;

  always_ff @(posedge clock) begin
    if (push) begin
      fifoDstE[tail] <= dstE;
      fifoDstM[tail] <= dstM;
      fifoValE[tail] <= valE;
      fifoValM[tail] <= valM;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count      <= 3'd0;
      head       <= 2'd0;
      tail       <= 2'd0;
      writeRegE  <= NoReg;
      writeRegM  <= NoReg;
      writeDataE <= 64'd0;
      writeDataM <= 64'd0;
    end else begin
      if (flush) begin
        count <= 3'd0;
        head  <= 2'd0;
        tail  <= 2'd0;
      end else begin
        if (push) tail <= tail + 2'd1;
        if (pop)  head <= head + 2'd1;
        case ({push, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
      writeRegE <= NoReg;
      writeRegM <= NoReg;
      if (pop) begin
        // Same destination on both ports: the memory result is the architecturally later write.
        writeRegE  <= (fifoDstE[head] == fifoDstM[head]) ? NoReg : fifoDstE[head];
        writeRegM  <= fifoDstM[head];
        writeDataE <= fifoValE[head];
        writeDataM <= fifoValM[head];
      end
    end
  end

  function automatic logic regHit(input logic [3:0] q, input logic [3:0] d);
    return (q != NoReg) && (d == q);
  endfunction

  always_comb begin
    entryValid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      entryValid[i] = {1'b0, 2'(2'(i) - head)} < count;
    end
  end

  // Pending writes are anything still queued plus whatever is on the write ports this cycle.
  always_comb begin
    busyA = regHit(qRegA, writeRegE) || regHit(qRegA, writeRegM);
    busyB = regHit(qRegB, writeRegE) || regHit(qRegB, writeRegM);
    for (int i = 0; i < 4; i++) begin
      if (entryValid[i]) begin
        if (regHit(qRegA, fifoDstE[i]) || regHit(qRegA, fifoDstM[i])) busyA = 1'b1;
        if (regHit(qRegB, fifoDstE[i]) || regHit(qRegB, fifoDstM[i])) busyB = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed vector bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

  logic        clock = 1'b0;
  logic        reset, inValid, inReady, hold, flush, busyA, busyB;
  logic [3:0]  dstE, dstM, writeRegE, writeRegM, qRegA, qRegB;
  logic [63:0] valE, valM, writeDataE, writeDataM;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  regfile_writeback_queue dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .hold(hold), .flush(flush),
    .writeRegE(writeRegE), .writeRegM(writeRegM),
    .writeDataE(writeDataE), .writeDataM(writeDataM),
    .qRegA(qRegA), .qRegB(qRegB), .busyA(busyA), .busyB(busyB)
  );

  typedef struct {
    logic        rst, inV;
    logic [3:0]  dE, dM;
    logic [63:0] vE, vM;
    logic        hld, fl;
    logic [3:0]  qA, qB;
    logic        eReady, eBusyA, eBusyB;
    logic [3:0]  eWrE, eWrM;
    logic        chkE, chkM;
    logic [63:0] eWdE, eWdM;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chkWrite(input string tag, input logic [3:0] eE, input logic [3:0] eM);
    chk({tag, ".writeRegE"}, 64'(writeRegE), 64'(eE));
    chk({tag, ".writeRegM"}, 64'(writeRegM), 64'(eM));
  endtask

  initial begin
    reset = 1'b0; inValid = 1'b0; hold = 1'b0; flush = 1'b0;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; qRegA = 4'hF; qRegB = 4'hF;

    // rst inV dE dM vE vM hld fl qA qB | ready bA bB | wrE wrM chkE chkM wdE wdM
    vecs[0]  = '{0,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'hF,4'hF, 0,0,0, 4'hF,4'hF, 1,1,64'h0, 64'h0};
    vecs[1]  = '{1,1,4'h2,4'hF,64'h10,64'h0, 0,0,4'h2,4'hF, 1,0,0, 4'hF,4'hF, 1,1,64'h0, 64'h0};
    vecs[2]  = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'h2,4'hF, 1,1,0, 4'h2,4'hF, 1,1,64'h10,64'h0};
    vecs[3]  = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'h2,4'hF, 1,1,0, 4'hF,4'hF, 1,1,64'h10,64'h0};
    vecs[4]  = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'h2,4'hF, 1,0,0, 4'hF,4'hF, 1,1,64'h10,64'h0};
    vecs[5]  = '{1,1,4'h5,4'h5,64'hAA,64'hBB,0,0,4'h5,4'hF, 1,0,0, 4'hF,4'hF, 1,1,64'h10,64'h0};
    vecs[6]  = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'hF,4'h5, 1,0,1, 4'hF,4'h5, 0,1,64'h0, 64'hBB};
    vecs[7]  = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'hF,4'h5, 1,0,1, 4'hF,4'hF, 0,1,64'h0, 64'hBB};
    vecs[8]  = '{1,1,4'hF,4'hF,64'h1, 64'h2, 0,0,4'hF,4'hF, 1,0,0, 4'hF,4'hF, 0,1,64'h0, 64'hBB};
    vecs[9]  = '{1,1,4'h7,4'hF,64'h77,64'h0, 0,0,4'h7,4'hF, 1,0,0, 4'hF,4'hF, 0,0,64'h0, 64'h0};
    vecs[10] = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'h7,4'hF, 1,1,0, 4'h7,4'hF, 1,1,64'h77,64'h0};
    vecs[11] = '{1,0,4'hF,4'hF,64'h0, 64'h0, 0,0,4'h7,4'hF, 1,1,0, 4'hF,4'hF, 1,1,64'h77,64'h0};

    tick();
    tick();

    for (int v = 0; v < 12; v++) begin
      reset = vecs[v].rst; inValid = vecs[v].inV; dstE = vecs[v].dE; dstM = vecs[v].dM;
      valE = vecs[v].vE; valM = vecs[v].vM; hold = vecs[v].hld; flush = vecs[v].fl;
      qRegA = vecs[v].qA; qRegB = vecs[v].qB;
      #1;
      chk($sformatf("v%0d.inReady", v), 64'(inReady), 64'(vecs[v].eReady));
      chk($sformatf("v%0d.busyA", v), 64'(busyA), 64'(vecs[v].eBusyA));
      chk($sformatf("v%0d.busyB", v), 64'(busyB), 64'(vecs[v].eBusyB));
      tick();
      chkWrite($sformatf("v%0d", v), vecs[v].eWrE, vecs[v].eWrM);
      if (vecs[v].chkE) chk($sformatf("v%0d.writeDataE", v), writeDataE, vecs[v].eWdE);
      if (vecs[v].chkM) chk($sformatf("v%0d.writeDataM", v), writeDataM, vecs[v].eWdM);
    end

    // Fill under hold, offer to a full queue, then drain in order.
    inValid = 1'b0; qRegA = 4'hF; qRegB = 4'hF;
    hold = 1'b1; inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dstE = 4'(i + 1); dstM = 4'(i + 8); valE = 64'h100 + 64'(i); valM = 64'h200 + 64'(i);
      #1;
      chk($sformatf("fill%0d.inReady", i), 64'(inReady), 64'd1);
      tick();
      chkWrite($sformatf("fill%0d", i), 4'hF, 4'hF);
    end
    dstE = 4'hC; dstM = 4'hF; qRegA = 4'h8;
    #1;
    chk("full.inReady", 64'(inReady), 64'd0);
    chk("hold.busyA", 64'(busyA), 64'd1);
    tick();
    chkWrite("full", 4'hF, 4'hF);
    qRegA = 4'hF;
    #1;
    chk("holdF.busyA", 64'(busyA), 64'd0);
    hold = 1'b0; dstE = 4'hD;
    #1;
    chk("fullpop.inReady", 64'(inReady), 64'd0);
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      chkWrite($sformatf("drain%0d", i), 4'(i + 1), 4'(i + 8));
      chk($sformatf("drain%0d.writeDataE", i), writeDataE, 64'h100 + 64'(i));
      chk($sformatf("drain%0d.writeDataM", i), writeDataM, 64'h200 + 64'(i));
    end
    tick();
    chkWrite("drained", 4'hF, 4'hF);
    qRegA = 4'h8; qRegB = 4'hD;
    #1;
    chk("drained.busyA", 64'(busyA), 64'd0);
    chk("drained.busyB", 64'(busyB), 64'd0);
    tick();
    chkWrite("drained2", 4'hF, 4'hF);

    // Flush with a concurrent offer.
    qRegA = 4'hF; qRegB = 4'hF; hold = 1'b1; inValid = 1'b1; dstM = 4'hF;
    for (int i = 0; i < 3; i++) begin
      dstE = 4'(i + 1); valE = 64'h30 + 64'(i);
      tick();
    end
    flush = 1'b1; hold = 1'b0; dstE = 4'h9;
    tick();
    chkWrite("flush", 4'hF, 4'hF);
    flush = 1'b0; inValid = 1'b0; qRegA = 4'h9;
    #1;
    chk("flush.busyA", 64'(busyA), 64'd0);
    chk("flush.inReady", 64'(inReady), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkWrite($sformatf("postflush%0d", i), 4'hF, 4'hF);
    end
    hold = 1'b1; inValid = 1'b1; qRegA = 4'hF;
    for (int i = 0; i < 4; i++) begin
      dstE = 4'(i); 
      #1;
      chk($sformatf("refill%0d.inReady", i), 64'(inReady), 64'd1);
      tick();
    end
    chk("refill.inReady", 64'(inReady), 64'd0);
    inValid = 1'b0; hold = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;

    // Reset in the middle of a drain.
    hold = 1'b1; inValid = 1'b1; dstM = 4'hF;
    dstE = 4'h4; valE = 64'h44; tick();
    dstE = 4'h5; valE = 64'h55; tick();
    inValid = 1'b0; hold = 1'b0;
    tick();
    chkWrite("middrain", 4'h4, 4'hF);
    chk("middrain.writeDataE", writeDataE, 64'h44);
    reset = 1'b0;
    #1;
    chk("inreset.inReady", 64'(inReady), 64'd0);
    tick();
    chkWrite("reset", 4'hF, 4'hF);
    chk("reset.writeDataE", writeDataE, 64'h0);
    chk("reset.writeDataM", writeDataM, 64'h0);
    reset = 1'b1; inValid = 1'b1; dstE = 4'h6; valE = 64'h66; valM = 64'h0;
    #1;
    chk("postreset.inReady", 64'(inReady), 64'd1);
    tick();
    chkWrite("postreset", 4'hF, 4'hF);
    inValid = 1'b0;
    tick();
    chkWrite("firstpush", 4'h6, 4'hF);
    chk("firstpush.writeDataE", writeDataE, 64'h66);
    tick();
    chkWrite("firstpush.after", 4'hF, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
